// File: rtl/mem_arbiter.sv
// mem_arbiter: single owner of the byte-wide RAM/IO port, serving instruction fetch and the load/store buffer.
// Revision 1.0
`default_nettype none

module mem_arbiter #(
  parameter logic [1:0] IO_HI = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        jump_wrong_stall,
  input  logic        if_req_flag,
  input  logic [31:0] if_req_addr,
  output logic        if_done_flag,
  output logic [31:0] if_done_data,
  input  logic        lsb_req_flag,
  input  logic [1:0]  lsb_req_width,
  input  logic        lsb_req_type,
  input  logic        lsb_req_sext,
  input  logic [31:0] lsb_req_addr,
  input  logic [31:0] lsb_req_data,
  input  logic [31:0] lsb_req_rob_id,
  output logic        lsb_done_flag,
  output logic        ld_cdb_flag,
  output logic [31:0] ld_cdb_rob_id,
  output logic [31:0] ld_cdb_val,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_IF_RD   = 3'd1,
    S_LS_RD   = 3'd2,
    S_LS_WR   = 3'd3,
    S_IO_WAIT = 3'd4
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_cnt, w_cnt_nxt;
  logic [1:0]  r_last, w_last_nxt;
  logic [31:0] r_addr, w_addr_nxt;
  logic [31:0] r_data, w_data_nxt;
  logic [31:0] r_rob, w_rob_nxt;
  logic        r_sext, w_sext_nxt;
  logic        r_stalled, w_stalled_nxt;
  logic [31:0] r_buf, w_buf_nxt;
  logic [31:0] r_mem_a, w_mem_a_nxt;
  logic [7:0]  r_mem_dout, w_mem_dout_nxt;
  logic        r_mem_wr, w_mem_wr_nxt;
  logic        r_if_done, w_if_done_nxt;
  logic [31:0] r_if_data, w_if_data_nxt;
  logic        r_lsb_done, w_lsb_done_nxt;
  logic        r_cdb_flag, w_cdb_flag_nxt;
  logic [31:0] r_cdb_rob, w_cdb_rob_nxt;
  logic [31:0] r_cdb_val, w_cdb_val_nxt;

  logic [1:0]  w_cnt_inc;
  logic [31:0] w_addr_inc;
  logic [31:0] w_addr_cur;
  logic [31:0] w_fill;
  logic [31:0] w_ld_val;
  logic        w_io_req;
  logic        w_io_cur;

  function automatic logic [7:0] byte_of(input logic [31:0] d, input logic [1:0] i);
    case (i)
      2'd0:    byte_of = d[7:0];
      2'd1:    byte_of = d[15:8];
      2'd2:    byte_of = d[23:16];
      default: byte_of = d[31:24];
    endcase
  endfunction

  assign w_cnt_inc  = r_cnt + 2'd1;
  assign w_addr_inc = r_addr + {30'd0, w_cnt_inc};
  assign w_addr_cur = r_addr + {30'd0, r_cnt};
  assign w_io_req   = (lsb_req_addr[17:16] == IO_HI);
  assign w_io_cur   = (r_addr[17:16] == IO_HI);

  // Assembled word including the byte arriving this cycle.
  always_comb begin
    w_fill = r_buf;
    case (r_cnt)
      2'd0:    w_fill[7:0]   = mem_din;
      2'd1:    w_fill[15:8]  = mem_din;
      2'd2:    w_fill[23:16] = mem_din;
      default: w_fill[31:24] = mem_din;
    endcase
  end

  always_comb begin
    case (r_last)
      2'd0:    w_ld_val = {{24{w_fill[7] & r_sext}}, w_fill[7:0]};
      2'd1:    w_ld_val = {{16{w_fill[15] & r_sext}}, w_fill[15:0]};
      default: w_ld_val = w_fill;
    endcase
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_last_nxt     = r_last;
    w_addr_nxt     = r_addr;
    w_data_nxt     = r_data;
    w_rob_nxt      = r_rob;
    w_sext_nxt     = r_sext;
    w_stalled_nxt  = r_stalled;
    w_buf_nxt      = r_buf;
    w_mem_a_nxt    = r_mem_a;
    w_mem_dout_nxt = r_mem_dout;
    w_mem_wr_nxt   = 1'b0;
    w_if_done_nxt  = 1'b0;
    w_if_data_nxt  = r_if_data;
    w_lsb_done_nxt = 1'b0;
    w_cdb_flag_nxt = 1'b0;
    w_cdb_rob_nxt  = r_cdb_rob;
    w_cdb_val_nxt  = r_cdb_val;

    case (r_state)
      S_IDLE: begin
        // A request seen while our done pulse is out is the LSB's stale re-pulse.
        if (lsb_req_flag && !r_lsb_done) begin
          w_addr_nxt    = lsb_req_addr;
          w_data_nxt    = lsb_req_data;
          w_rob_nxt     = lsb_req_rob_id;
          w_sext_nxt    = lsb_req_sext;
          w_last_nxt    = (lsb_req_width == 2'b00) ? 2'd0 :
                          (lsb_req_width == 2'b01) ? 2'd1 : 2'd3;
          w_cnt_nxt     = 2'd0;
          w_buf_nxt     = 32'd0;
          w_stalled_nxt = jump_wrong_stall;
          w_mem_a_nxt   = lsb_req_addr;
          if (!lsb_req_type) begin
            w_state_nxt = S_LS_RD;
          end else if (w_io_req && io_buffer_full) begin
            w_state_nxt = S_IO_WAIT;
          end else begin
            w_state_nxt    = S_LS_WR;
            w_mem_wr_nxt   = 1'b1;
            w_mem_dout_nxt = lsb_req_data[7:0];
          end
        end else if (if_req_flag && !jump_wrong_stall) begin
          w_addr_nxt  = if_req_addr;
          w_last_nxt  = 2'd3;
          w_cnt_nxt   = 2'd0;
          w_buf_nxt   = 32'd0;
          w_mem_a_nxt = if_req_addr;
          w_state_nxt = S_IF_RD;
        end
      end

      S_IF_RD: begin
        if (jump_wrong_stall) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_buf_nxt = w_fill;
          if (r_cnt == r_last) begin
            w_if_done_nxt = 1'b1;
            w_if_data_nxt = w_fill;
            w_state_nxt   = S_IDLE;
          end else begin
            w_cnt_nxt   = w_cnt_inc;
            w_mem_a_nxt = w_addr_inc;
          end
        end
      end

      S_LS_RD: begin
        w_buf_nxt     = w_fill;
        w_stalled_nxt = r_stalled | jump_wrong_stall;
        if (r_cnt == r_last) begin
          w_lsb_done_nxt = 1'b1;
          w_cdb_flag_nxt = !(r_stalled || jump_wrong_stall);
          w_cdb_rob_nxt  = r_rob;
          w_cdb_val_nxt  = w_ld_val;
          w_state_nxt    = S_IDLE;
        end else begin
          w_cnt_nxt   = w_cnt_inc;
          w_mem_a_nxt = w_addr_inc;
        end
      end

      S_LS_WR: begin
        if (r_cnt == r_last) begin
          w_lsb_done_nxt = 1'b1;
          w_state_nxt    = S_IDLE;
        end else begin
          w_cnt_nxt   = w_cnt_inc;
          w_mem_a_nxt = w_addr_inc;
          if (w_io_cur && io_buffer_full) begin
            w_state_nxt = S_IO_WAIT;
          end else begin
            w_mem_wr_nxt   = 1'b1;
            w_mem_dout_nxt = byte_of(r_data, w_cnt_inc);
          end
        end
      end

      S_IO_WAIT: begin
        // r_cnt already points at the byte still owed to the IO port.
        if (!io_buffer_full) begin
          w_state_nxt    = S_LS_WR;
          w_mem_wr_nxt   = 1'b1;
          w_mem_a_nxt    = w_addr_cur;
          w_mem_dout_nxt = byte_of(r_data, r_cnt);
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 2'd0;
      r_last     <= 2'd0;
      r_addr     <= 32'd0;
      r_data     <= 32'd0;
      r_rob      <= 32'd0;
      r_sext     <= 1'b0;
      r_stalled  <= 1'b0;
      r_buf      <= 32'd0;
      r_mem_a    <= 32'd0;
      r_mem_dout <= 8'd0;
      r_mem_wr   <= 1'b0;
      r_if_done  <= 1'b0;
      r_if_data  <= 32'd0;
      r_lsb_done <= 1'b0;
      r_cdb_flag <= 1'b0;
      r_cdb_rob  <= 32'd0;
      r_cdb_val  <= 32'd0;
    end else if (rdy) begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_last     <= w_last_nxt;
      r_addr     <= w_addr_nxt;
      r_data     <= w_data_nxt;
      r_rob      <= w_rob_nxt;
      r_sext     <= w_sext_nxt;
      r_stalled  <= w_stalled_nxt;
      r_buf      <= w_buf_nxt;
      r_mem_a    <= w_mem_a_nxt;
      r_mem_dout <= w_mem_dout_nxt;
      r_mem_wr   <= w_mem_wr_nxt;
      r_if_done  <= w_if_done_nxt;
      r_if_data  <= w_if_data_nxt;
      r_lsb_done <= w_lsb_done_nxt;
      r_cdb_flag <= w_cdb_flag_nxt;
      r_cdb_rob  <= w_cdb_rob_nxt;
      r_cdb_val  <= w_cdb_val_nxt;
    end
  end

  assign if_done_flag  = r_if_done;
  assign if_done_data  = r_if_data;
  assign lsb_done_flag = r_lsb_done;
  assign ld_cdb_flag   = r_cdb_flag;
  assign ld_cdb_rob_id = r_cdb_rob;
  assign ld_cdb_val    = r_cdb_val;
  assign mem_a         = r_mem_a;
  assign mem_dout      = r_mem_dout;
  assign mem_wr        = r_mem_wr & rdy;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with queued expectations checked by a free-running monitor.
// Revision 1.0
`default_nettype none

module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        jump_wrong_stall;
  logic        if_req_flag;
  logic [31:0] if_req_addr;
  logic        if_done_flag;
  logic [31:0] if_done_data;
  logic        lsb_req_flag;
  logic [1:0]  lsb_req_width;
  logic        lsb_req_type;
  logic        lsb_req_sext;
  logic [31:0] lsb_req_addr;
  logic [31:0] lsb_req_data;
  logic [31:0] lsb_req_rob_id;
  logic        lsb_done_flag;
  logic        ld_cdb_flag;
  logic [31:0] ld_cdb_rob_id;
  logic [31:0] ld_cdb_val;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  mem_arbiter #(.IO_HI(2'b11)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jump_wrong_stall(jump_wrong_stall),
    .if_req_flag(if_req_flag), .if_req_addr(if_req_addr),
    .if_done_flag(if_done_flag), .if_done_data(if_done_data),
    .lsb_req_flag(lsb_req_flag), .lsb_req_width(lsb_req_width),
    .lsb_req_type(lsb_req_type), .lsb_req_sext(lsb_req_sext),
    .lsb_req_addr(lsb_req_addr), .lsb_req_data(lsb_req_data),
    .lsb_req_rob_id(lsb_req_rob_id), .lsb_done_flag(lsb_done_flag),
    .ld_cdb_flag(ld_cdb_flag), .ld_cdb_rob_id(ld_cdb_rob_id), .ld_cdb_val(ld_cdb_val),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  typedef struct packed {
    logic        cdb;
    logic [31:0] rob;
    logic [31:0] val;
  } ls_exp_t;

  logic [31:0] ifq[$];
  ls_exp_t     lsq[$];
  logic [39:0] wq[$];
  int          checks = 0;
  int          errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    case (a)
      32'h1000: ram_rd = 8'h13;
      32'h1001: ram_rd = 8'h05;
      32'h0020: ram_rd = 8'h80;
      32'h0022: ram_rd = 8'h34;
      32'h0023: ram_rd = 8'hF2;
      32'h0050: ram_rd = 8'h11;
      32'h0051: ram_rd = 8'h22;
      32'h0052: ram_rd = 8'h33;
      32'h0053: ram_rd = 8'h44;
      default:  ram_rd = 8'h00;
    endcase
  endfunction

  // Byte addressed on the previous edge is visible before the next one.
  always_comb mem_din = ram_rd(mem_a);

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic exp_ls(input logic cdb, input logic [31:0] rob, input logic [31:0] val);
    ls_exp_t e;
    e.cdb = cdb;
    e.rob = rob;
    e.val = val;
    lsq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (mem_wr === 1'b1) begin
      if (wq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write actual=0x%08h/0x%02h required=none", mem_a, mem_dout);
      end else begin
        logic [39:0] w;
        w = wq.pop_front();
        check32("write_addr", mem_a, w[39:8]);
        check32("write_data", {24'd0, mem_dout}, {24'd0, w[7:0]});
      end
    end
    if (if_done_flag === 1'b1) begin
      if (ifq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_if_done actual=0x%08h required=none", if_done_data);
      end else begin
        check32("if_data", if_done_data, ifq.pop_front());
      end
    end
    if (lsb_done_flag === 1'b1) begin
      if (lsq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_lsb_done actual=1 required=0");
      end else begin
        ls_exp_t e;
        e = lsq.pop_front();
        check32("cdb_flag", {31'd0, ld_cdb_flag}, {31'd0, e.cdb});
        if (e.cdb) begin
          check32("cdb_rob", ld_cdb_rob_id, e.rob);
          check32("cdb_val", ld_cdb_val, e.val);
        end
      end
    end else if (ld_cdb_flag === 1'b1) begin
      checks++; errors++;
      $display("FAIL cdb_without_done actual=1 required=0");
    end
  end

  task automatic wait_if(output int cyc);
    cyc = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      cyc = k + 1;
      if (if_done_flag) break;
    end
    if (!if_done_flag) begin
      checks++; errors++;
      $display("FAIL if_done_timeout actual=0 required=1");
    end
  endtask

  task automatic wait_lsb(output int cyc);
    cyc = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      cyc = k + 1;
      if (lsb_done_flag) break;
    end
    if (!lsb_done_flag) begin
      checks++; errors++;
      $display("FAIL lsb_done_timeout actual=0 required=1");
    end
  endtask

  task automatic lsb_set(input logic [1:0] w, input logic t, input logic s,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] rob);
    lsb_req_flag   = 1'b1;
    lsb_req_width  = w;
    lsb_req_type   = t;
    lsb_req_sext   = s;
    lsb_req_addr   = a;
    lsb_req_data   = d;
    lsb_req_rob_id = rob;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Load issued, held through its done cycle so the stale re-pulse is exercised.
  task automatic do_load(input logic [1:0] w, input logic s, input logic [31:0] a,
                         input logic [31:0] rob, input logic [31:0] val, input int lat);
    int cyc;
    exp_ls(1'b1, rob, val);
    lsb_set(w, 1'b0, s, a, 32'd0, rob);
    @(negedge clk);
    check32("load_accept_addr", mem_a, a);
    wait_lsb(cyc);
    check32("load_latency", cyc, lat);
    @(negedge clk);
    lsb_req_flag = 1'b0;
    idle(2);
  endtask

  initial begin
    int cyc;
    int cnt;
    rst = 1'b1; rdy = 1'b0; jump_wrong_stall = 1'b0;
    if_req_flag = 1'b0; if_req_addr = 32'd0;
    lsb_req_flag = 1'b0; lsb_req_width = 2'b00; lsb_req_type = 1'b0; lsb_req_sext = 1'b0;
    lsb_req_addr = 32'd0; lsb_req_data = 32'd0; lsb_req_rob_id = 32'd0;
    io_buffer_full = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check32("rst_mem_a", mem_a, 32'd0);
    check32("rst_flags", {27'd0, if_done_flag, lsb_done_flag, ld_cdb_flag, mem_wr, 1'b0}, 32'd0);
    check32("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    check32("rst_if_data", if_done_data, 32'd0);
    check32("rst_cdb_val", ld_cdb_val, 32'd0);
    check32("rst_cdb_rob", ld_cdb_rob_id, 32'd0);

    // Fetch pending while rdy is low, then accepted on the first rdy cycle.
    rst = 1'b0;
    if_req_flag = 1'b1; if_req_addr = 32'h1000;
    ifq.push_back(32'h0000_0513);
    idle(2);
    check32("frozen_mem_a", mem_a, 32'd0);
    rdy = 1'b1;
    @(negedge clk);
    check32("if_accept_addr", mem_a, 32'h1000);
    wait_if(cyc);
    if_req_flag = 1'b0;
    check32("if_latency", cyc, 4);
    idle(2);

    do_load(2'b00, 1'b1, 32'h20, 32'd7,  32'hFFFF_FF80, 1);
    do_load(2'b00, 1'b0, 32'h20, 32'd8,  32'h0000_0080, 1);
    do_load(2'b01, 1'b1, 32'h22, 32'd9,  32'hFFFF_F234, 2);
    do_load(2'b11, 1'b0, 32'h50, 32'd12, 32'h4433_2211, 4);

    // Store and fetch requested together; store wins, fetch follows.
    wq.push_back({32'h40, 8'hEF});
    wq.push_back({32'h41, 8'hBE});
    wq.push_back({32'h42, 8'hAD});
    wq.push_back({32'h43, 8'hDE});
    exp_ls(1'b0, 32'd0, 32'd0);
    ifq.push_back(32'h0000_0513);
    lsb_set(2'b11, 1'b1, 1'b0, 32'h40, 32'hDEAD_BEEF, 32'd3);
    if_req_flag = 1'b1; if_req_addr = 32'h1000;
    @(negedge clk);
    check32("store_first_addr", mem_a, 32'h40);
    wait_lsb(cyc);
    check32("store_latency", cyc, 4);
    @(negedge clk);
    lsb_req_flag = 1'b0;
    check32("if_after_store_addr", mem_a, 32'h1000);
    wait_if(cyc);
    if_req_flag = 1'b0;
    check32("if_after_store_latency", cyc, 4);
    idle(2);

    // IO store held off by a full buffer for three cycles.
    wq.push_back({32'h0003_0004, 8'h5A});
    exp_ls(1'b0, 32'd0, 32'd0);
    lsb_set(2'b00, 1'b1, 1'b0, 32'h0003_0004, 32'h0000_005A, 32'd4);
    io_buffer_full = 1'b1;
    @(negedge clk);
    lsb_req_flag = 1'b0;
    check32("io_wait_wr_0", {31'd0, mem_wr}, 32'd0);
    @(negedge clk);
    check32("io_wait_wr_1", {31'd0, mem_wr}, 32'd0);
    @(negedge clk);
    check32("io_wait_wr_2", {31'd0, mem_wr}, 32'd0);
    io_buffer_full = 1'b0;
    @(negedge clk);
    check32("io_write_wr", {31'd0, mem_wr}, 32'd1);
    @(negedge clk);
    check32("io_done", {31'd0, lsb_done_flag}, 32'd1);
    idle(2);

    // Flush during a fetch: abort with address held, then a fresh fetch from IDLE.
    if_req_flag = 1'b1; if_req_addr = 32'h1000;
    @(negedge clk);
    @(negedge clk);
    jump_wrong_stall = 1'b1;
    if_req_flag = 1'b0;
    @(negedge clk);
    jump_wrong_stall = 1'b0;
    check32("if_abort_mem_a", mem_a, 32'h1001);
    check32("if_abort_no_done", {31'd0, if_done_flag}, 32'd0);
    ifq.push_back(32'h0000_0513);
    if_req_flag = 1'b1;
    @(negedge clk);
    check32("if_reaccept_addr", mem_a, 32'h1000);
    wait_if(cyc);
    if_req_flag = 1'b0;
    check32("if_reaccept_latency", cyc, 4);
    idle(2);

    // Flush during a word load: done still pulses, broadcast suppressed.
    exp_ls(1'b0, 32'd0, 32'd0);
    lsb_set(2'b11, 1'b0, 1'b0, 32'h50, 32'd0, 32'd5);
    @(negedge clk);
    lsb_req_flag = 1'b0;
    @(negedge clk);
    jump_wrong_stall = 1'b1;
    @(negedge clk);
    jump_wrong_stall = 1'b0;
    wait_lsb(cyc);
    check32("flush_load_latency", cyc, 2);
    idle(2);

    // Reset mid-load: the access vanishes without a done pulse.
    lsb_set(2'b11, 1'b0, 1'b0, 32'h50, 32'd0, 32'd6);
    @(negedge clk);
    lsb_req_flag = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check32("midrst_mem_a", mem_a, 32'd0);
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      cnt += int'(lsb_done_flag);
    end
    check32("midrst_no_done", cnt, 0);

    check32("ifq_drained", ifq.size(), 0);
    check32("lsq_drained", lsq.size(), 0);
    check32("wq_drained", wq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit actual=expired required=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule

`default_nettype wire
